bcd_auto_counter: RTL and testbench

//  Free-running multi-digit BCD counter: stepping rate set by a prescaler, direction and pause selectable.

---
 rtl/bcd_auto_counter.sv | 162 ++++++++++++++++
 tb/tb_bcd_auto_counter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_auto_counter.sv
// bcd_auto_counter
//   Free-running multi-digit BCD counter with a prescaled step rate,
//   selectable direction and pause. The count is time-multiplexed onto a
//   single 4-bit BCD bus (digit) with a one-hot, active-high digit enable
//   (an), ready for a downstream 7-segment decoder.
//
// Parameters
//   DIGITS    number of BCD digits (1..8), digit 0 is least significant
//   DIV       clk cycles per count step (>=2)
//   SCAN_DIV  clk cycles per scan-slot advance (>=1)
//
// Ports
//   clk       system clock, all state on the rising edge
//   rst       synchronous reset, active-high
//   en        1 = prescaler runs, 0 = pause (count frozen, scan continues)
//   up        1 = count up, 0 = count down (sampled on the step cycle)
//   clear     synchronous clear of count and prescaler
//   load      synchronous load of load_val (nibbles above 9 stored as 9)
//   load_val  packed BCD load value, digit i at [4i+3:4i]
//   bcd       current packed BCD count
//   digit     BCD value of the currently scanned digit
//   an        one-hot select of the currently scanned digit
//   step      one-cycle pulse coinciding with each new stepped count
//   wrap      one-cycle pulse when a step wraps (all-9 -> 0 or 0 -> all-9)
module bcd_auto_counter #(
    parameter int DIGITS   = 4,
    parameter int DIV      = 100_000_000,
    parameter int SCAN_DIV = 100_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [3:0]            digit,
    output logic [DIGITS-1:0]     an,
    output logic                  step,
    output logic                  wrap
);

    localparam int PSC_W = (DIV > 1)      ? $clog2(DIV)      : 1;
    localparam int SCN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1)   ? $clog2(DIGITS)   : 1;

    localparam logic [PSC_W-1:0]  PSC_MAX = PSC_W'(DIV - 1);
    localparam logic [SCN_W-1:0]  SCN_MAX = SCN_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_MAX = IDX_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0] AN_RST  = DIGITS'(1);

    // Per-digit saturation of a packed BCD word: any nibble above 9 becomes 9.
    function automatic logic [4*DIGITS-1:0] clamp_digits(input logic [4*DIGITS-1:0] v);
        logic [4*DIGITS-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                r[4*i +: 4] = 4'd9;
            end
        end
        return r;
    endfunction

    // One BCD step in either direction. The MSB of the result is the carry
    // (or borrow) out of the top digit, which is exactly the wrap condition.
    function automatic logic [4*DIGITS:0] bcd_next(input logic [4*DIGITS-1:0] v,
                                                   input logic dir_up);
        logic [4*DIGITS-1:0] r;
        logic                c;
        logic [3:0]          d;
        r = v;
        c = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            d = v[4*i +: 4];
            if (c) begin
                if (dir_up) begin
                    if (d >= 4'd9) begin
                        r[4*i +: 4] = 4'd0;
                    end else begin
                        r[4*i +: 4] = d + 4'd1;
                        c           = 1'b0;
                    end
                end else begin
                    if (d == 4'd0) begin
                        r[4*i +: 4] = 4'd9;
                    end else begin
                        r[4*i +: 4] = d - 4'd1;
                        c           = 1'b0;
                    end
                end
            end
        end
        return {c, r};
    endfunction

    logic [PSC_W-1:0]    psc;
    logic [SCN_W-1:0]    scnt;
    logic [IDX_W-1:0]    idx;
    logic [IDX_W+1:0]    sel_lsb;
    logic                step_p0;
    logic [4*DIGITS:0]   nxt_p0;

    // Stage p0: decide whether this cycle is a step cycle and what the count becomes
    always_comb begin
        step_p0 = en && (psc == PSC_MAX);
        nxt_p0  = bcd_next(bcd, up);
    end

    assign sel_lsb = {idx, 2'b00};

    // Stage p1: count, prescaler and registered step/wrap pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            bcd  <= '0;
            psc  <= '0;
            step <= 1'b0;
            wrap <= 1'b0;
        end else if (clear) begin
            bcd  <= '0;
            psc  <= '0;
            step <= 1'b0;
            wrap <= 1'b0;
        end else if (load) begin
            bcd  <= clamp_digits(load_val);
            psc  <= '0;
            step <= 1'b0;
            wrap <= 1'b0;
        end else begin
            step <= step_p0;
            wrap <= step_p0 && nxt_p0[4*DIGITS];
            if (step_p0) begin
                bcd <= nxt_p0[4*DIGITS-1:0];
            end
            // Prescaler only moves while enabled, so a pause resumes exactly
            // where it left off.
            if (en) begin
                psc <= step_p0 ? '0 : psc + 1'b1;
            end
        end
    end

    // Scan: free-running, only rst disturbs it
    always_ff @(posedge clk) begin
        if (rst) begin
            scnt  <= '0;
            idx   <= '0;
            digit <= 4'd0;
            an    <= AN_RST;
        end else begin
            digit <= bcd[sel_lsb +: 4];
            an    <= AN_RST << idx;
            if (scnt == SCN_MAX) begin
                scnt <= '0;
                idx  <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
            end else begin
                scnt <= scnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bcd_auto_counter.sv
// tb_bcd_auto_counter
//   Scoreboard bench for bcd_auto_counter (DIGITS=4, DIV=4, SCAN_DIV=2).
//   The driver applies inputs on the falling edge, advances a decimal
//   reference model and queues the expected registered outputs; a separate
//   monitor pops one record after each rising edge and compares.
module tb_bcd_auto_counter;

    localparam int DIGITS   = 4;
    localparam int DIV      = 4;
    localparam int SCAN_DIV = 2;
    localparam int MODULUS  = 10000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        up = 1'b1;
    logic        clear = 1'b0;
    logic        load = 1'b0;
    logic [15:0] load_val = 16'h0000;
    logic [15:0] bcd;
    logic [3:0]  digit;
    logic [3:0]  an;
    logic        step;
    logic        wrap;

    bcd_auto_counter #(
        .DIGITS  (DIGITS),
        .DIV     (DIV),
        .SCAN_DIV(SCAN_DIV)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .up      (up),
        .clear   (clear),
        .load    (load),
        .load_val(load_val),
        .bcd     (bcd),
        .digit   (digit),
        .an      (an),
        .step    (step),
        .wrap    (wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bcd;
        logic        step;
        logic        wrap;
        logic [3:0]  digit;
        logic [3:0]  an;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model state: count as a plain integer 0..9999
    int   m_cnt = 0;
    int   m_psc = 0;
    int   m_scnt = 0;
    int   m_idx = 0;

    function automatic int pow10(input int n);
        int p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
        return r;
    endfunction

    function automatic int load_to_int(input logic [15:0] lv);
        int      val;
        int      nib;
        val = 0;
        for (int i = 0; i < DIGITS; i++) begin
            nib = int'(lv[4*i +: 4]);
            if (nib > 9) nib = 9;
            val = val + nib * pow10(i);
        end
        return val;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Apply one cycle of inputs, advance the model, queue expected outputs.
    task automatic drive(input logic r, input logic e, input logic u,
                         input logic c, input logic l, input logic [15:0] lv);
        exp_t x;
        bit   s;
        @(negedge clk);
        rst = r; en = e; up = u; clear = c; load = l; load_val = lv;
        // Scan outputs reflect the state before this edge
        x.digit = 4'((m_cnt / pow10(m_idx)) % 10);
        x.an    = 4'(1 << m_idx);
        x.step  = 1'b0;
        x.wrap  = 1'b0;
        if (r) begin
            m_cnt = 0; m_psc = 0; m_scnt = 0; m_idx = 0;
            x.digit = 4'd0;
            x.an    = 4'b0001;
        end else begin
            if (m_scnt == SCAN_DIV - 1) begin
                m_scnt = 0;
                m_idx  = (m_idx + 1) % DIGITS;
            end else begin
                m_scnt++;
            end
            if (c) begin
                m_cnt = 0; m_psc = 0;
            end else if (l) begin
                m_cnt = load_to_int(lv); m_psc = 0;
            end else begin
                s = e && (m_psc == DIV - 1);
                if (e) m_psc = (m_psc + 1) % DIV;
                x.step = s;
                if (s) begin
                    if (u) begin
                        x.wrap = (m_cnt == MODULUS - 1);
                        m_cnt  = (m_cnt + 1) % MODULUS;
                    end else begin
                        x.wrap = (m_cnt == 0);
                        m_cnt  = (m_cnt + MODULUS - 1) % MODULUS;
                    end
                end
            end
        end
        x.bcd = to_bcd(m_cnt);
        q.push_back(x);
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("bcd",   bcd,           e.bcd);
                chk("step",  {15'd0, step}, {15'd0, e.step});
                chk("wrap",  {15'd0, wrap}, {15'd0, e.wrap});
                chk("digit", {12'd0, digit}, {12'd0, e.digit});
                chk("an",    {12'd0, an},   {12'd0, e.an});
            end
        end
    end

    initial begin
        logic [15:0] lv;
        int          pick;
        // Initial reset, short count, then reset mid-count
        drive(1, 0, 1, 0, 0, 16'h0);
        repeat (9) drive(0, 1, 1, 0, 0, 16'h0);
        drive(1, 1, 1, 0, 0, 16'h0);
        // Up count 40 cycles from 0 -> 0010
        repeat (40) drive(0, 1, 1, 0, 0, 16'h0);
        // Up wrap from 9999, then one step down back to 9999
        drive(0, 0, 1, 0, 1, 16'h9999);
        repeat (4) drive(0, 1, 1, 0, 0, 16'h0);
        repeat (4) drive(0, 1, 0, 0, 0, 16'h0);
        // Pause at psc=2 for 10 cycles, then resume
        drive(0, 0, 1, 0, 1, 16'h0042);
        repeat (2) drive(0, 1, 1, 0, 0, 16'h0);
        repeat (10) drive(0, 0, 1, 0, 0, 16'h0);
        repeat (4) drive(0, 1, 1, 0, 0, 16'h0);
        // Clear and load together on a step cycle; then load with a bad nibble
        drive(0, 0, 1, 0, 1, 16'h0777);
        repeat (3) drive(0, 1, 1, 0, 0, 16'h0);
        drive(0, 1, 1, 1, 1, 16'h1234);
        drive(0, 0, 1, 0, 0, 16'h0);
        drive(0, 0, 1, 0, 1, 16'h12F4);
        repeat (2) drive(0, 0, 1, 0, 0, 16'h0);
        // Scan data with a frozen count
        drive(0, 0, 1, 0, 1, 16'h5678);
        repeat (12) drive(0, 0, 1, 0, 0, 16'h0);
        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            pick = int'($urandom_range(0, 3));
            case (pick)
                0:       lv = 16'h9999;
                1:       lv = 16'h0000;
                2:       lv = 16'h9998;
                default: lv = 16'($urandom);
            endcase
            drive($urandom_range(0, 199) == 0,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 2) != 0,
                  $urandom_range(0, 79) == 0,
                  $urandom_range(0, 59) == 0,
                  lv);
        end
        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d records left, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
